// File: rtl/conv_pixel_scheduler.sv
// Per-output-pixel scheduler: fills the conv engine's patch buffer, starts the engine and
// drains its output batches to the output feature map. Define CONV_PIXEL_SCHED_PERF_EN for perf_cycles.
module conv_pixel_scheduler #(
  parameter int unsigned ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [9:0]        cfg_h,
  input  logic [9:0]        cfg_w,
  input  logic [10:0]       cfg_c_in,
  input  logic [10:0]       cfg_c_out,
  input  logic [3:0]        cfg_kernel,
  input  logic [1:0]        cfg_stride,
  output logic              fmap_rd_en,
  output logic [ADDR_W-1:0] fmap_rd_addr,
  input  logic signed [7:0] fmap_rd_data,
  output logic              patch_wr_en,
  output logic [10:0]       patch_wr_addr,
  output logic [7:0]        patch_wr_data,
  output logic              eng_start,
  input  logic              eng_out_valid,
  input  logic [8:0]        eng_out_ch_base,
  input  logic [5:0]        eng_out_count,
  input  logic [255:0]      eng_out_data_flat,
  input  logic              eng_done,
  output logic              ofm_wr_en,
  output logic [ADDR_W-1:0] ofm_wr_addr,
  output logic [7:0]        ofm_wr_data,
  output logic              busy,
  output logic              done,
  output logic              overrun
`ifdef CONV_PIXEL_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  typedef enum logic [2:0] {
    StIdle, StFillReq, StFillLat, StEngStart, StEngRun, StNextPix, StDone
  } state_e;

  state_e state_q, state_d;

  // Latched layer configuration
  logic [9:0]  h_q, w_q, oh_q, ow_q;
  logic [10:0] cin_q, cout_q;
  logic [3:0]  k_q;
  logic        stride2_q, pad_q;

  // Pixel and patch iteration
  logic [9:0]  oy_q, ox_q;
  logic [10:0] c_q, patch_idx_q;
  logic [3:0]  ky_q, kx_q;
  logic        eng_done_seen_q;

  // Drain buffer
  logic [255:0] drain_data_q, drain_data_d;
  logic [8:0]   drain_base_q, drain_base_d;
  logic [5:0]   drain_cnt_q, drain_cnt_d;
  logic [5:0]   drain_lane_q, drain_lane_d;
  logic         drain_active_q, drain_active_d;
  logic         drain_capture;
  logic         overrun_q, overrun_d;

  logic unused_cfg;
  assign unused_cfg = ^cout_q;

  function automatic logic [9:0] out_dim(input logic [9:0] dim, input logic [3:0] k,
                                         input logic s2);
    logic [10:0] num;
    num = {1'b0, dim} + {9'b0, (k == 4'd3), 1'b0} - {7'b0, k};
    return s2 ? (num[10:1] + 10'd1) : (num[9:0] + 10'd1);
  endfunction

  logic start_accept;
  assign start_accept = (state_q == StIdle) && start;

  // Input coordinates; padding underflow is caught on the raw sum, before any multiply
  logic [10:0] iy_base, ix_base;
  logic [11:0] iy_raw, ix_raw, iy, ix;
  logic        iy_oob, ix_oob, oob;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    iy_base = stride2_q ? {oy_q, 1'b0} : {1'b0, oy_q};
    ix_base = stride2_q ? {ox_q, 1'b0} : {1'b0, ox_q};
    iy_raw  = {1'b0, iy_base} + {8'b0, ky_q};
    ix_raw  = {1'b0, ix_base} + {8'b0, kx_q};
    iy      = iy_raw - {11'b0, pad_q};
    ix      = ix_raw - {11'b0, pad_q};
    iy_oob  = (pad_q && (iy_raw == 12'd0)) || (iy >= {2'b0, h_q});
    ix_oob  = (pad_q && (ix_raw == 12'd0)) || (ix >= {2'b0, w_q});
    oob     = iy_oob || ix_oob;
    rd_addr = (ADDR_W'(c_q) * ADDR_W'(h_q) + ADDR_W'(iy)) * ADDR_W'(w_q) + ADDR_W'(ix);
  end

  logic kx_last, ky_last, c_last, elem_last, pix_last, fill_adv;
  assign kx_last   = (kx_q == k_q - 4'd1);
  assign ky_last   = (ky_q == k_q - 4'd1);
  assign c_last    = (c_q == cin_q - 11'd1);
  assign elem_last = kx_last && ky_last && c_last;
  assign pix_last  = (oy_q == oh_q - 10'd1) && (ox_q == ow_q - 10'd1);
  assign fill_adv  = ((state_q == StFillReq) && oob) || (state_q == StFillLat);

  // Drain next state: a new batch always wins, even over an unfinished drain
  always_comb begin
    drain_capture  = (state_q == StEngRun) && eng_out_valid;
    drain_data_d   = drain_data_q;
    drain_base_d   = drain_base_q;
    drain_cnt_d    = drain_cnt_q;
    drain_lane_d   = drain_lane_q;
    drain_active_d = drain_active_q;
    overrun_d      = overrun_q;
    if (drain_capture) begin
      drain_data_d   = eng_out_data_flat;
      drain_base_d   = eng_out_ch_base;
      drain_cnt_d    = (eng_out_count > 6'd32) ? 6'd32 : eng_out_count;
      drain_lane_d   = '0;
      drain_active_d = (eng_out_count != 6'd0);
      if (drain_active_q) overrun_d = 1'b1;
    end else if (drain_active_q) begin
      if (drain_lane_q == drain_cnt_q - 6'd1) drain_active_d = 1'b0;
      else drain_lane_d = drain_lane_q + 6'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start) state_d = StFillReq;
      StFillReq:  begin
        if (!oob)          state_d = StFillLat;
        else if (elem_last) state_d = StEngStart;
      end
      StFillLat:  state_d = elem_last ? StEngStart : StFillReq;
      StEngStart: state_d = StEngRun;
      StEngRun:   if ((eng_done_seen_q || eng_done) && !drain_active_d) state_d = StNextPix;
      StNextPix:  state_d = pix_last ? StDone : StFillReq;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    fmap_rd_en    = 1'b0;
    fmap_rd_addr  = '0;
    patch_wr_en   = 1'b0;
    patch_wr_addr = '0;
    patch_wr_data = '0;
    eng_start     = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      StFillReq: begin
        if (!oob) begin
          fmap_rd_en   = 1'b1;
          fmap_rd_addr = rd_addr;
        end else begin
          patch_wr_en   = 1'b1;
          patch_wr_addr = patch_idx_q;
        end
      end
      StFillLat: begin
        patch_wr_en   = 1'b1;
        patch_wr_addr = patch_idx_q;
        patch_wr_data = fmap_rd_data;
      end
      StEngStart: eng_start = 1'b1;
      StDone:     done      = 1'b1;
      default: ;
    endcase
    busy        = (state_q != StIdle);
    overrun     = overrun_q;
    ofm_wr_en   = drain_active_q;
    ofm_wr_addr = '0;
    ofm_wr_data = '0;
    if (drain_active_q) begin
      ofm_wr_addr = ((ADDR_W'(drain_base_q) + ADDR_W'(drain_lane_q)) * ADDR_W'(oh_q)
                     + ADDR_W'(oy_q)) * ADDR_W'(ow_q) + ADDR_W'(ox_q);
      ofm_wr_data = drain_data_q[{drain_lane_q[4:0], 3'b000} +: 8];
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0; w_q <= '0; oh_q <= '0; ow_q <= '0;
      cin_q <= '0; cout_q <= '0; k_q <= '0;
      stride2_q <= 1'b0; pad_q <= 1'b0;
      oy_q <= '0; ox_q <= '0; c_q <= '0; patch_idx_q <= '0;
      ky_q <= '0; kx_q <= '0;
      eng_done_seen_q <= 1'b0;
      drain_data_q <= '0; drain_base_q <= '0; drain_cnt_q <= '0;
      drain_lane_q <= '0; drain_active_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (start_accept) begin
        h_q       <= cfg_h;
        w_q       <= cfg_w;
        cin_q     <= cfg_c_in;
        cout_q    <= cfg_c_out;
        k_q       <= cfg_kernel;
        stride2_q <= (cfg_stride == 2'd2);
        pad_q     <= (cfg_kernel == 4'd3);
        oh_q      <= out_dim(cfg_h, cfg_kernel, cfg_stride == 2'd2);
        ow_q      <= out_dim(cfg_w, cfg_kernel, cfg_stride == 2'd2);
        oy_q <= '0; ox_q <= '0; c_q <= '0; ky_q <= '0; kx_q <= '0; patch_idx_q <= '0;
      end
      // Patch index follows c, ky, kx order, so it is simply a running count
      if (fill_adv) begin
        patch_idx_q <= patch_idx_q + 11'd1;
        if (kx_last) begin
          kx_q <= '0;
          if (ky_last) begin
            ky_q <= '0;
            c_q  <= c_q + 11'd1;
          end else begin
            ky_q <= ky_q + 4'd1;
          end
        end else begin
          kx_q <= kx_q + 4'd1;
        end
      end
      if (state_q == StNextPix) begin
        c_q <= '0; ky_q <= '0; kx_q <= '0; patch_idx_q <= '0;
        if (ox_q == ow_q - 10'd1) begin
          ox_q <= '0;
          oy_q <= oy_q + 10'd1;
        end else begin
          ox_q <= ox_q + 10'd1;
        end
      end
      if (state_q == StEngStart)                 eng_done_seen_q <= 1'b0;
      else if (state_q == StEngRun && eng_done) eng_done_seen_q <= 1'b1;
      drain_data_q   <= drain_data_d;
      drain_base_q   <= drain_base_d;
      drain_cnt_q    <= drain_cnt_d;
      drain_lane_q   <= drain_lane_d;
      drain_active_q <= drain_active_d;
      overrun_q      <= overrun_d;
    end
  end

`ifdef CONV_PIXEL_SCHED_PERF_EN
  // Stall cycles: engine running with nothing left to drain
  logic [31:0] perf_q;
  always_ff @(posedge clk) begin
    if (rst)                                            perf_q <= '0;
    else if (start_accept)                              perf_q <= '0;
    else if (state_q == StEngRun && !drain_active_q)    perf_q <= perf_q + 32'd1;
  end
  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_pixel_scheduler.sv
// Scoreboard bench for conv_pixel_scheduler: a behavioural engine pushes expected ofm writes,
// a negedge monitor pops and compares them.
module tb_conv_pixel_scheduler;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst, start;
  logic [9:0]  cfg_h, cfg_w;
  logic [10:0] cfg_c_in, cfg_c_out;
  logic [3:0]  cfg_kernel;
  logic [1:0]  cfg_stride;
  logic        fmap_rd_en;
  logic [AW-1:0] fmap_rd_addr;
  logic signed [7:0] fmap_rd_data;
  logic        patch_wr_en;
  logic [10:0] patch_wr_addr;
  logic [7:0]  patch_wr_data;
  logic        eng_start, eng_out_valid, eng_done;
  logic [8:0]  eng_out_ch_base;
  logic [5:0]  eng_out_count;
  logic [255:0] eng_out_data_flat;
  logic        ofm_wr_en;
  logic [AW-1:0] ofm_wr_addr;
  logic [7:0]  ofm_wr_data;
  logic        busy, done, overrun;

  conv_pixel_scheduler #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_c_in(cfg_c_in), .cfg_c_out(cfg_c_out),
    .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride),
    .fmap_rd_en(fmap_rd_en), .fmap_rd_addr(fmap_rd_addr), .fmap_rd_data(fmap_rd_data),
    .patch_wr_en(patch_wr_en), .patch_wr_addr(patch_wr_addr), .patch_wr_data(patch_wr_data),
    .eng_start(eng_start), .eng_out_valid(eng_out_valid), .eng_out_ch_base(eng_out_ch_base),
    .eng_out_count(eng_out_count), .eng_out_data_flat(eng_out_data_flat), .eng_done(eng_done),
    .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr), .ofm_wr_data(ofm_wr_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [27:0]   exp_q[$];
  logic [27:0]   sb_e;
  logic [AW-1:0] ofm_log[$];
  logic [AW-1:0] rd_log[$];
  logic [10:0]   patch_addr_log[$];
  logic [7:0]    patch_data_log[$];
  int done_cnt, eng_start_cnt;
  int eng_mode;  // 0 normal, 1 second batch 5 cycles after first, 2 one batch then silence
  int t_oh, t_ow, t_cout, pix;

  // Hand-derived tables (fmap[a] = a*3+1)
  int t2_patch[9] = '{0, 0, 0, 0, 1, 4, 0, 10, 13};
  int t2_reads[4] = '{0, 1, 3, 4};
  int t3_reads[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] data_of(input int ch, input int p);
    return 8'(ch * 5 + p * 17 + 3);
  endfunction

  // Feature-map memory: one-cycle read latency
  initial begin
    fmap_rd_data = '0;
    forever begin
      @(posedge clk);
      if (fmap_rd_en) fmap_rd_data = 8'(fmap_rd_addr * 3 + 1);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (ofm_wr_en) begin
      ofm_log.push_back(ofm_wr_addr);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL ofm_write: got addr %0d data %0d, expected no write", ofm_wr_addr,
                 ofm_wr_data);
      end else begin
        sb_e = exp_q.pop_front();
        if ({ofm_wr_addr, ofm_wr_data} !== sb_e) begin
          n_errors++;
          $display("FAIL ofm_write: got addr %0d data %0d, expected addr %0d data %0d",
                   ofm_wr_addr, ofm_wr_data, sb_e[27:8], sb_e[7:0]);
        end
      end
    end
    if (patch_wr_en) begin
      patch_addr_log.push_back(patch_wr_addr);
      patch_data_log.push_back(patch_wr_data);
    end
    if (fmap_rd_en) rd_log.push_back(fmap_rd_addr);
    if (done) done_cnt++;
    if (eng_start) eng_start_cnt++;
  end

  // Behavioural engine
  task automatic run_pixel(input int p);
    int remaining, base, cnt, gap, nexp, oy, ox;
    logic [255:0] flat;
    oy = p / t_ow;
    ox = p % t_ow;
    repeat (2) @(negedge clk);
    remaining = t_cout;
    base = 0;
    while (remaining > 0) begin
      cnt = (remaining > 32) ? 32 : remaining;
      remaining -= cnt;
      gap  = (eng_mode == 1 && base == 0) ? 5 : cnt + 3;
      nexp = (remaining == 0 || gap > cnt) ? cnt : gap;
      if (eng_mode == 2) nexp = 3;
      for (int i = 0; i < 32; i++) flat[i*8 +: 8] = (i < cnt) ? data_of(base + i, p) : 8'hEE;
      for (int i = 0; i < nexp; i++)
        exp_q.push_back({AW'(((base + i) * t_oh + oy) * t_ow + ox), data_of(base + i, p)});
      eng_out_valid = 1'b1;
      eng_out_ch_base = 9'(base);
      eng_out_count = 6'(cnt);
      eng_out_data_flat = flat;
      @(negedge clk);
      eng_out_valid = 1'b0;
      if (eng_mode == 2) return;
      if (remaining == 0) begin
        // eng_done lands on the same edge as the final drain write
        repeat (cnt - 1) @(negedge clk);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
      end else begin
        repeat (gap - 1) @(negedge clk);
      end
      base += cnt;
    end
  endtask

  initial begin
    eng_out_valid = 1'b0;
    eng_done = 1'b0;
    eng_out_ch_base = '0;
    eng_out_count = '0;
    eng_out_data_flat = '0;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        run_pixel(pix);
        pix++;
      end
    end
  end

  task automatic start_layer(input int h, input int w, input int cin, input int cout,
                             input int k, input int s, input int oh, input int ow);
    ofm_log.delete(); rd_log.delete(); patch_addr_log.delete(); patch_data_log.delete();
    done_cnt = 0; eng_start_cnt = 0; pix = 0;
    t_oh = oh; t_ow = ow; t_cout = cout;
    cfg_h = 10'(h); cfg_w = 10'(w); cfg_c_in = 11'(cin); cfg_c_out = 11'(cout);
    cfg_kernel = 4'(k); cfg_stride = 2'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Configuration must already be latched
    cfg_h = '0; cfg_w = '0; cfg_c_in = '0; cfg_c_out = '0; cfg_kernel = '0; cfg_stride = '0;
  endtask

  task automatic run_layer(input string name, input int h, input int w, input int cin,
                           input int cout, input int k, input int s, input int oh, input int ow);
    int cyc;
    logic seen;
    start_layer(h, w, cin, cout, k, s, oh, ow);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(seen), 1);
    start = 1'b1;  // coincides with done: must be ignored
    @(negedge clk);
    start = 1'b0;
    chk({name, "_start_during_done_ignored"}, 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk({name, "_scoreboard_empty"}, exp_q.size(), 0);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_eng_starts"}, eng_start_cnt, oh * ow);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; eng_mode = 0;
    cfg_h = '0; cfg_w = '0; cfg_c_in = '0; cfg_c_out = '0; cfg_kernel = '0; cfg_stride = '0;
    t_oh = 1; t_ow = 1; t_cout = 0; pix = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_strobes", {28'(0), fmap_rd_en, patch_wr_en, eng_start, ofm_wr_en}, 0);
    chk("reset_done_overrun", {30'(0), done, overrun}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1x1 kernel, 2 input channels, 3 output channels
    run_layer("t1", 2, 2, 2, 3, 1, 1, 2, 2);
    chk("t1_reads", rd_log.size(), 8);
    chk("t1_patch_writes", patch_addr_log.size(), 8);
    chk("t1_ofm_writes", ofm_log.size(), 12);
    chk("t1_pix10_ch2_addr", ofm_log[8], 10);
    chk("t1_read1_addr", rd_log[1], 4);
    chk("t1_patch1_data", patch_data_log[1], 13);

    // 3x3 with padding
    run_layer("t2", 3, 3, 1, 2, 3, 1, 3, 3);
    chk("t2_patch_writes", patch_addr_log.size(), 81);
    chk("t2_reads", rd_log.size(), 49);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t2_patch_addr%0d", i), patch_addr_log[i], i);
      chk($sformatf("t2_patch_data%0d", i), patch_data_log[i], t2_patch[i]);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t2_read%0d", i), rd_log[i], t2_reads[i]);

    // Stride 2
    run_layer("t3", 4, 4, 1, 1, 3, 2, 2, 2);
    chk("t3_reads", rd_log.size(), 25);
    for (int i = 0; i < 9; i++) chk($sformatf("t3_pix11_read%0d", i), rd_log[16+i], t3_reads[i]);
    chk("t3_ofm_last_addr", ofm_log[3], 3);

    // Output-channel tiling
    run_layer("t4", 2, 2, 1, 40, 1, 1, 2, 2);
    chk("t4_ofm_writes", ofm_log.size(), 160);
    chk("t4_ch32_addr", ofm_log[32], 128);
    chk("t4_no_overrun", 32'(overrun), 0);

    // Overrun: second batch 5 cycles after a 32-lane batch
    eng_mode = 1;
    run_layer("t5", 1, 1, 1, 64, 1, 1, 1, 1);
    eng_mode = 0;
    chk("t5_overrun", 32'(overrun), 1);
    chk("t5_ofm_writes", ofm_log.size(), 37);
    chk("t5_restart_addr", ofm_log[5], 32);
    repeat (10) @(negedge clk);
    chk("t5_overrun_sticky", 32'(overrun), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_overrun_cleared", 32'(overrun), 0);

    // Reset in the middle of a drain
    eng_mode = 2;
    start_layer(2, 2, 1, 40, 1, 1, 2, 2);
    cyc = 0;
    while (!ofm_wr_en && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_drain_started", 32'(ofm_wr_en), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_strobes", {28'(0), fmap_rd_en, patch_wr_en, eng_start, ofm_wr_en}, 0);
    chk("t6_rst_flags", {30'(0), done, overrun}, 0);
    chk("t6_rst_addrs", 32'(fmap_rd_addr) | 32'(patch_wr_addr) | 32'(ofm_wr_addr), 0);
    rst = 1'b0;
    eng_mode = 0;
    repeat (2) @(negedge clk);
    chk("t6_partial_drain", exp_q.size(), 0);
    run_layer("t6b", 2, 2, 2, 3, 1, 1, 2, 2);
    chk("t6b_ofm_writes", ofm_log.size(), 12);
    chk("t6b_pix10_ch2_addr", ofm_log[8], 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
